// File: rtl/tag_scan_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tag_scan_ctl
// Purpose  : Scans a small tag table through one shared external equality
//            comparator; reports hit/miss and the lowest matching index.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tag_scan_ctl #(
  parameter int ENTRIES = 4,
  parameter int IDXW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [5:0]      key,
  output logic            ack,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx,
  input  logic            wr,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [5:0]      wr_tag,
  input  logic            wr_val,
  output logic [5:0]      cmp_a,
  output logic [5:0]      cmp_b,
  input  logic            cmp_equal_n
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [IDXW-1:0]      ptr, ptr_nx;
  logic [5:0]           key_r, key_nx;
  logic                 hit_r, hit_nx;
  logic [IDXW-1:0]      idx_r, idx_nx;
  logic [5:0]           tag_q [ENTRIES];
  logic [ENTRIES-1:0]   valid;
  logic                 match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      key_r <= '0;
      hit_r <= 1'b0;
      idx_r <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      key_r <= key_nx;
      hit_r <= hit_nx;
      idx_r <= idx_nx;
    end
  end

  // Writes land at the edge, so the entry under the pointer this cycle is
  // always compared with its pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
      end
      valid <= '0;
    end else if (wr) begin
      tag_q[wr_idx] <= wr_tag;
      valid[wr_idx] <= wr_val;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    key_nx   = key_r;
    hit_nx   = hit_r;
    idx_nx   = idx_r;
    ack      = 1'b0;
    match    = valid[ptr] & ~cmp_equal_n;
    case (state)
      IDLE: begin
        if (req) begin
          ack      = 1'b1;
          key_nx   = key;
          ptr_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_nx   = 1'b1;
          idx_nx   = ptr;
          state_nx = DONE;
        end else if (ptr == LAST_IDX) begin
          hit_nx   = 1'b0;
          idx_nx   = '0;
          state_nx = DONE;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy    = (state == SCAN) || (state == DONE);
  assign done    = (state == DONE);
  assign hit     = hit_r;
  assign hit_idx = idx_r;
  assign cmp_a   = key_r;
  assign cmp_b   = tag_q[ptr];

endmodule
`default_nettype wire

// File: tb/tb_tag_scan_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_tag_scan_ctl
// Purpose  : Self-checking bench for tag_scan_ctl with a cycle-timeline model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tag_scan_ctl;

  localparam int ENTRIES = 4;
  localparam int IDXW    = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req = 1'b0;
  logic [5:0]      key = '0;
  logic            ack, busy, done, hit;
  logic [IDXW-1:0] hit_idx;
  logic            wr = 1'b0;
  logic [IDXW-1:0] wr_idx = '0;
  logic [5:0]      wr_tag = '0;
  logic            wr_val = 1'b0;
  logic [5:0]      cmp_a, cmp_b;
  logic            cmp_equal_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ack = -1;
  int last_done = -1;

  tag_scan_ctl #(.ENTRIES(ENTRIES), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .key(key), .ack(ack), .busy(busy),
    .done(done), .hit(hit), .hit_idx(hit_idx), .wr(wr), .wr_idx(wr_idx),
    .wr_tag(wr_tag), .wr_val(wr_val), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_equal_n(cmp_equal_n)
  );

  // The shared external comparator.
  assign cmp_equal_n = (cmp_a != cmp_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: a lookup accepted in cycle s compares entry e in cycle
  // s+1+e against the table as it stands in that cycle; done follows the
  // first matching cycle, or the cycle of the last entry.
  logic [5:0] m_tag [ENTRIES];
  bit         m_val [ENTRIES];
  logic [5:0] m_key;
  bit         m_hit, m_known;
  int         m_idx, m_ptr, m_start, m_done_at;

  always @(negedge clk) begin
    bit busy_e, done_e, scan_e, ack_e;
    int e;
    if (m_known) begin
      done_e = (m_done_at == cyc);
      busy_e = (m_start >= 0) && (cyc > m_start);
      scan_e = busy_e && !done_e;
      e      = scan_e ? (cyc - m_start - 1) : m_ptr;
      ack_e  = req && !busy_e;
      check("ack", 32'(ack), 32'(ack_e));
      check("busy", 32'(busy), 32'(busy_e));
      check("done", 32'(done), 32'(done_e));
      check("hit", 32'(hit), 32'(m_hit));
      check("hit_idx", 32'(hit_idx), 32'(m_idx));
      check("cmp_a", 32'(cmp_a), 32'(m_key));
      check("cmp_b", 32'(cmp_b), 32'(m_tag[e]));
      if (scan_e) begin
        m_ptr = e;
        if (m_val[e] && m_tag[e] == m_key) begin
          m_done_at = cyc + 1; m_hit = 1'b1; m_idx = e;
        end else if (e == ENTRIES - 1) begin
          m_done_at = cyc + 1; m_hit = 1'b0; m_idx = 0;
        end
      end
      if (done_e) m_start = -1;
      if (ack_e) begin
        m_start = cyc; m_key = key; m_done_at = -1; m_ptr = 0;
      end
      if (wr) begin
        m_tag[wr_idx] = wr_tag;
        m_val[wr_idx] = wr_val;
      end
    end
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_tag[i] = '0; m_val[i] = 1'b0;
      end
      m_key = '0; m_hit = 1'b0; m_idx = 0; m_ptr = 0;
      m_start = -1; m_done_at = -1; m_known = 1'b1;
    end
  end

  task automatic write_entry(input int idx, input logic [5:0] tag, input bit val);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    wr = 1'b1; wr_idx = IDXW'(idx); wr_tag = tag; wr_val = val;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // Issues one lookup; optional write or reset is driven in cycle n after ack.
  task automatic lookup(input logic [5:0] k, input bit exp_hit, input int exp_idx,
                        input int exp_lat, input bit hold, input int wr_at,
                        input int widx, input logic [5:0] wtag, input bit wval,
                        input int rst_at);
    bit got;
    int t0;
    @(posedge clk); #1;
    wr = 1'b0; reset = 1'b0; req = 1'b1; key = k;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      req = 1'b0;
      return;
    end
    t0 = cyc;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      wr = (n == wr_at); wr_idx = IDXW'(widx); wr_tag = wtag; wr_val = wval;
      reset = (n == rst_at);
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (rst_at > 0) begin
      check("no_done_after_reset", 32'(got), 32'd0);
    end else begin
      check("done_seen", 32'(got), 32'd1);
      check("done_latency", 32'(cyc - t0), 32'(exp_lat));
      check("result_hit", 32'(hit), 32'(exp_hit));
      check("result_idx", 32'(hit_idx), 32'(exp_idx));
    end
    last_ack  = t0;
    last_done = cyc;
  endtask

  initial begin
    int prev_done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_idx", 32'(hit_idx), 32'd0);
    check("rst_cmp_a", 32'(cmp_a), 32'd0);
    check("rst_cmp_b", 32'(cmp_b), 32'd0);

    // Empty table: zero tags must not match because nothing is valid.
    lookup(6'h15, 1'b0, 0, 5, 1'b0, -1, 0, 6'h00, 1'b0, -1);
    lookup(6'h00, 1'b0, 0, 5, 1'b0, -1, 0, 6'h00, 1'b0, -1);

    write_entry(2, 6'h2A, 1'b1);
    lookup(6'h2A, 1'b1, 2, 4, 1'b0, -1, 0, 6'h00, 1'b0, -1);

    write_entry(1, 6'h07, 1'b1);
    write_entry(3, 6'h07, 1'b1);
    lookup(6'h07, 1'b1, 1, 3, 1'b0, -1, 0, 6'h00, 1'b0, -1);
    write_entry(1, 6'h07, 1'b0);
    lookup(6'h07, 1'b1, 3, 5, 1'b0, -1, 0, 6'h00, 1'b0, -1);

    // Mid-scan writes: ahead of the pointer takes effect, under it does not.
    write_entry(3, 6'h00, 1'b1);
    lookup(6'h3F, 1'b1, 3, 5, 1'b0, 2, 3, 6'h3F, 1'b1, -1);
    lookup(6'h3F, 1'b1, 3, 5, 1'b0, 1, 0, 6'h3F, 1'b1, -1);
    lookup(6'h3F, 1'b1, 0, 2, 1'b0, -1, 0, 6'h00, 1'b0, -1);

    // Continuous req: next accept lands the cycle after done.
    lookup(6'h3F, 1'b1, 0, 2, 1'b1, -1, 0, 6'h00, 1'b0, -1);
    prev_done = last_done;
    lookup(6'h2A, 1'b1, 2, 4, 1'b1, -1, 0, 6'h00, 1'b0, -1);
    check("b2b_accept", 32'(last_ack - prev_done), 32'd1);
    @(posedge clk); #1 req = 1'b0;

    // Reset during a scan aborts it and wipes the table.
    write_entry(1, 6'h11, 1'b1);
    lookup(6'h11, 1'b0, 0, 0, 1'b0, -1, 0, 6'h00, 1'b0, 2);
    lookup(6'h11, 1'b0, 0, 5, 1'b0, -1, 0, 6'h00, 1'b0, -1);
    lookup(6'h2A, 1'b0, 0, 5, 1'b0, -1, 0, 6'h00, 1'b0, -1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/tag_scan_ctl.md
# tag_scan_ctl

Sequencing controller for the shared 6-bit equality comparator used by the duplicate-detect logic. It accepts a 6-bit lookup key from a requester and holds a small table of 6-bit tags with per-entry valid bits. It scans the table one entry per clock through a single external comparator (equal_n, active-low match) and reports hit/miss plus the lowest matching index. This replaces one comparator per entry with one comparator plus this block.

## Interface

Parameters:
- ENTRIES, 4, number of tag entries; power of two, 2..8.
- IDXW, 2, index width, equals log2(ENTRIES).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  lookup request; held with key until ack.
- key  in  6  lookup key; sampled when ack=1.
- ack  out  1  combinational, equals req & (state==IDLE); key is latched on this edge.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; result valid.
- hit  out  1  a match was found; updated with done, held until the next done.
- hit_idx  out  IDXW  index of the matching entry; 0 on a miss; held like hit.
- wr  in  1  table write strobe, accepted in any state.
- wr_idx  in  IDXW  entry to write.
- wr_tag  in  6  tag value.
- wr_val  in  1  valid bit written with the tag; 0 invalidates the entry.
- cmp_a  out  6  comparator operand A, the latched key register.
- cmp_b  out  6  comparator operand B, the tag at the scan pointer.
- cmp_equal_n  in  1  comparator result, combinational from cmp_a/cmp_b; 0 means equal.

## Operation

- States: IDLE, SCAN, DONE. Scan pointer ptr is IDXW bits wide.
- IDLE:
  - If req=1: ack=1, key_r<=key, ptr<=0, go to SCAN.
  - Otherwise hold.
- SCAN, each cycle:
  - match = valid[ptr] & ~cmp_equal_n.
  - If match: hit_r<=1, idx_r<=ptr, go to DONE.
  - Else if ptr==ENTRIES-1: hit_r<=0, idx_r<=0, go to DONE.
  - Else: ptr<=ptr+1.
- DONE: done=1 for exactly one cycle, then go to IDLE. ack=0 in DONE, even if req=1.
- The scan runs in ascending order, so the lowest matching index wins when tags are duplicated.
- Invalid entries never match, even if their tag equals the key.
- cmp_b = tag[ptr] in every state. cmp_a = key_r in every state.
- Table writes:
  - tag[wr_idx]<=wr_tag and valid[wr_idx]<=wr_val at the clock edge when wr=1.
  - The entry compared in the same SCAN cycle uses its pre-write value.
  - An entry at index > ptr that is written mid-scan is compared with its new value.
  - Writes never stall or restart a scan.
- Reset:
  - State<=IDLE, ptr<=0, key_r<=0, all valid<=0, tags<=0, hit_r<=0, idx_r<=0.
  - Outputs after reset: ack=req, busy=0, done=0, hit=0, hit_idx=0, cmp_a=0, cmp_b=0.
  - Reset mid-scan aborts the lookup; no done is issued for it.
  - Reset wins over a simultaneous wr.

## Timing

- Cycle numbering: cycle 0 is the cycle where ack=1.
- Hit at index k: SCAN occupies cycles 1..k+1; done=1 in cycle k+2.
- Miss: SCAN occupies cycles 1..ENTRIES; done=1 in cycle ENTRIES+1. With ENTRIES=4, done is in cycle 5.
- hit/hit_idx become valid in the done cycle and stay stable until the next done.
- Throughput: a new request is accepted at the earliest in the cycle after done. Back-to-back requests with a hit at index 0 therefore give one lookup per 3 cycles.
- Datapath timing: the comparator path (cmp_b mux -> external XNOR/NAND -> match -> state) is combinational within one cycle.
- busy rises in cycle 1 and falls after the done cycle.

## Test plan

- Reset, then req with key=0x15 and an empty table -> ack in cycle 0, done in cycle 5, hit=0, hit_idx=0; no entry matches despite stored tags being 0.
- Write tag[2]=0x2A valid; req with key=0x2A -> done in cycle 4, hit=1, hit_idx=2, busy high in cycles 1..4.
- Write tag[1]=0x07 and tag[3]=0x07, both valid; key=0x07 -> hit_idx=1, done in cycle 3. Invalidate entry 1 and repeat -> hit_idx=3, done in cycle 5.
- Mid-scan write:
  - Key=0x3F with tag[3]=0x00 valid; write tag[3]=0x3F in cycle 2 -> hit=1, hit_idx=3 in cycle 5.
  - Write tag[0]=0x3F in cycle 1 of a fresh scan (entry 0 is being compared that cycle) -> entry 0 misses because the pre-write value is used.
- Hold req high continuously -> ack is 0 during SCAN/DONE and re-asserts in the cycle after done; hit/hit_idx hold their previous values until the new done.
- Assert reset in cycle 2 of a scan -> no done pulse, busy=0 next cycle, all valid cleared; a following lookup of a previously stored tag misses.
